// File: rtl/clkgen_pkg.sv
// Shared defaults and the limit helper for the multi-channel divided-clock generator.
// Constants only; no latency and no flow control.
package clkgen_pkg;

  localparam int unsigned CLKGEN_CNT_W         = 32;
  localparam int unsigned CLKGEN_DEFAULT_LIMIT = 25000;

  // Half-period limit that turns f_in into f_out.
  function automatic int unsigned calc_limit(input int unsigned f_in, input int unsigned f_out);
    return f_in / 2 / f_out;
  endfunction

endpackage

// File: rtl/clkgen_chan.sv
// One divider channel: counter, limit register and toggle/tick logic.
// Registered outputs; the first toggle comes after eff_lim enabled cycles. There is no backpressure.
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter int unsigned     CNT_W   = CLKGEN_CNT_W,
  parameter logic [CNT_W-1:0] RST_LIM = CNT_W'(CLKGEN_DEFAULT_LIMIT)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic             i_sync,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_clk,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_lim;
  logic             r_clk;
  logic             r_tick;

  logic [CNT_W-1:0] w_eff_lim;
  logic [CNT_W:0]   w_nxt;
  logic             w_hit;

  // A limit of 0 behaves like 1 so the channel never stalls.
  assign w_eff_lim = (r_lim == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : r_lim;
  // The extra MSB keeps an all-ones count from wrapping past the limit.
  assign w_nxt     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_hit     = (w_nxt >= {1'b0, w_eff_lim});

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_lim  <= RST_LIM;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (i_sync) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
      if (i_wr) begin
        r_lim <= i_limit;
      end
    end else if (i_wr) begin
      r_lim  <= i_limit;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_en) begin
      if (w_hit) begin
        r_cnt  <= '0;
        r_clk  <= ~r_clk;
        r_tick <= ~r_clk;
      end else begin
        r_cnt  <= w_nxt[CNT_W-1:0];
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;

endmodule

// File: rtl/clkgen_multi.sv
// NUM_CH independent divided clocks with rise strobes, plus limit-write decode; optional
// phase-align input under CLKGEN_MULTI_SYNC_EN. Registered outputs, no backpressure.
module clkgen_multi
  import clkgen_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_W         = CLKGEN_CNT_W,
  parameter int unsigned DEFAULT_LIMIT = CLKGEN_DEFAULT_LIMIT
) (
  input  logic                                         clkin,
  input  logic                                         rst,
`ifdef CLKGEN_MULTI_SYNC_EN
  input  logic                                         sync,
`endif
  input  logic [NUM_CH-1:0]                            clken,
  input  logic                                         cfg_wr,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                             cfg_limit,
  output logic [NUM_CH-1:0]                            clkout,
  output logic [NUM_CH-1:0]                            tick
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              w_sync;
  logic [NUM_CH-1:0] w_wr;

`ifdef CLKGEN_MULTI_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  // Indices at or above NUM_CH match no channel, so such writes are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = cfg_wr && (cfg_ch == CH_W'(g));

    clkgen_chan #(
      .CNT_W   (CNT_W),
      .RST_LIM (CNT_W'(DEFAULT_LIMIT))
    ) u_chan (
      .i_clk   (clkin),
      .i_rst_n (rst),
      .i_en    (clken[g]),
      .i_wr    (w_wr[g]),
      .i_sync  (w_sync),
      .i_limit (cfg_limit),
      .o_clk   (clkout[g]),
      .o_tick  (tick[g])
    );
  end

endmodule
